// File: rtl/read_pointer_empty_pkg.sv
// fifo_pkg: shared async-FIFO widths and Gray/binary pointer helpers.
package fifo_pkg;
  localparam int ADDR_WIDTH = 6;
  localparam int PTR_WIDTH = ADDR_WIDTH + 1;
  typedef logic [PTR_WIDTH-1:0] ptr_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  function automatic ptr_t bin2gray(input ptr_t b);
    return (b >> 1) ^ b;
  endfunction
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/read_pointer_empty_gray_to_binary.sv
// gray_to_binary: combinational Gray-to-binary conversion of a pointer.
module gray_to_binary #(
  parameter int PTR_WIDTH = 7
) (
  input  logic [PTR_WIDTH-1:0] i_gray,
  output logic [PTR_WIDTH-1:0] o_bin
);
  for (genvar g = 0; g < PTR_WIDTH; g++) begin : g_bit
    assign o_bin[g] = ^i_gray[PTR_WIDTH-1:g];
  end
endmodule

// File: rtl/read_pointer_empty.sv
// read_pointer_empty: read-domain pointer, RAM read address and registered
// empty / almost-empty / level / sticky-underflow status of the async FIFO.
module read_pointer_empty
  import fifo_pkg::*;
#(
  parameter int unsigned ALMOST_EMPTY_LEVEL = 4
) (
  input  logic                  clock_read,
  input  logic                  read_reset_n,
  input  logic                  read_enable,
  input  logic                  underflow_clear,
  input  logic [PTR_WIDTH-1:0]  sync_write_pointer,
  output logic [ADDR_WIDTH-1:0] read_address,
  output logic [PTR_WIDTH-1:0]  read_pointer,
  output logic                  read_empty,
  output logic                  read_almost_empty,
  output logic [PTR_WIDTH-1:0]  read_level,
  output logic                  read_underflow
);
  localparam ptr_t AE_LEVEL = PTR_WIDTH'(ALMOST_EMPTY_LEVEL);
  ptr_t r_rbin, r_rgray, r_level;
  logic r_empty, r_almost_empty, r_underflow;
  ptr_t w_wbin, w_rbin_next, w_rgray_next, w_level_next;
  logic w_accept;
  gray_to_binary #(.PTR_WIDTH(PTR_WIDTH)) u_g2b (
    .i_gray(sync_write_pointer),
    .o_bin (w_wbin)
  );
  assign w_accept = read_enable & ~r_empty;
  assign w_rbin_next = r_rbin + ptr_t'(w_accept);
  assign w_rgray_next = bin2gray(w_rbin_next);
  // Status is derived from next-state pointers so the last pop flags empty on its own edge.
  assign w_level_next = w_wbin - w_rbin_next;
  always_ff @(posedge clock_read or negedge read_reset_n) begin
    if (!read_reset_n) begin
      r_rbin <= '0;
      r_rgray <= '0;
      r_level <= '0;
      r_empty <= 1'b1;
      r_almost_empty <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      r_rbin <= w_rbin_next;
      r_rgray <= w_rgray_next;
      r_level <= w_level_next;
      r_empty <= w_rgray_next == sync_write_pointer;
      r_almost_empty <= w_level_next <= AE_LEVEL;
      r_underflow <= (read_enable & r_empty) | (r_underflow & ~underflow_clear);
    end
  end
  assign read_address = r_rbin[ADDR_WIDTH-1:0];
  assign read_pointer = r_rgray;
  assign read_empty = r_empty;
  assign read_almost_empty = r_almost_empty;
  assign read_level = r_level;
  assign read_underflow = r_underflow;
endmodule

// File: tb/tb_read_pointer_empty.sv
// tb_read_pointer_empty: directed stimulus feeding an expected-value queue,
// drained and compared once per read clock by an independent monitor.
module tb_read_pointer_empty;
  logic clock_read = 0;
  logic read_reset_n = 0;
  logic read_enable = 0;
  logic underflow_clear = 0;
  logic [6:0] sync_write_pointer = 0;
  logic [5:0] read_address;
  logic [6:0] read_pointer;
  logic read_empty, read_almost_empty, read_underflow;
  logic [6:0] read_level;
  int total = 0;
  int bad = 0;

  typedef struct {
    bit e;
    bit ae;
    bit uf;
    int lvl;
    int ptr;
    int addr;
  } exp_t;
  exp_t q[$];

  read_pointer_empty dut (
    .clock_read(clock_read),
    .read_reset_n(read_reset_n),
    .read_enable(read_enable),
    .underflow_clear(underflow_clear),
    .sync_write_pointer(sync_write_pointer),
    .read_address(read_address),
    .read_pointer(read_pointer),
    .read_empty(read_empty),
    .read_almost_empty(read_almost_empty),
    .read_level(read_level),
    .read_underflow(read_underflow)
  );

  always #5 clock_read = ~clock_read;

  function automatic logic [6:0] gray(input int b);
    logic [6:0] x;
    x = b[6:0];
    return x ^ (x >> 1);
  endfunction

  task automatic cmp(input string n, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, req, $time);
    end
  endtask

  task automatic step(input bit re, input bit uc, input int w, input int rb,
                      input bit e, input bit ae, input int lvl, input bit uf);
    exp_t x;
    @(negedge clock_read);
    read_reset_n = 1;
    read_enable = re;
    underflow_clear = uc;
    sync_write_pointer = gray(w % 128);
    x.e = e; x.ae = ae; x.uf = uf; x.lvl = lvl;
    x.ptr = int'(gray(rb % 128));
    x.addr = rb % 64;
    q.push_back(x);
  endtask

  task automatic rst_cyc();
    exp_t x;
    @(negedge clock_read);
    read_reset_n = 0;
    read_enable = 0;
    underflow_clear = 0;
    sync_write_pointer = 0;
    x.e = 1; x.ae = 1; x.uf = 0; x.lvl = 0; x.ptr = 0; x.addr = 0;
    q.push_back(x);
  endtask

  logic [6:0] prev_ptr = 0;
  always @(posedge clock_read) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      cmp("empty", int'(read_empty), int'(x.e));
      cmp("almost_empty", int'(read_almost_empty), int'(x.ae));
      cmp("underflow", int'(read_underflow), int'(x.uf));
      cmp("level", int'(read_level), x.lvl);
      cmp("pointer", int'(read_pointer), x.ptr);
      cmp("address", int'(read_address), x.addr);
    end
    if (!read_reset_n) prev_ptr = 0;
    else begin
      if (read_pointer != prev_ptr) cmp("gray_step", $countones(read_pointer ^ prev_ptr), 1);
      prev_ptr = read_pointer;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_cyc();
    rst_cyc();
    step(0, 0, 0, 0, 1, 1, 0, 0);
    // fill view: write pointer three ahead
    step(0, 0, 3, 0, 0, 1, 3, 0);
    step(1, 0, 3, 1, 0, 1, 2, 0);
    step(1, 0, 3, 2, 0, 1, 1, 0);
    step(1, 0, 3, 3, 1, 1, 0, 0);
    // underflow: ignored pop, sticky flag, clear, set beats clear
    step(1, 0, 3, 3, 1, 1, 0, 1);
    step(0, 0, 3, 3, 1, 1, 0, 1);
    step(0, 1, 3, 3, 1, 1, 0, 0);
    step(1, 1, 3, 3, 1, 1, 0, 1);
    step(0, 1, 3, 3, 1, 1, 0, 0);
    // walk the read pointer up to 120
    step(0, 0, 120, 3, 0, 0, 117, 0);
    for (int i = 1; i <= 117; i++)
      step(1, 0, 120, 3 + i, i == 117, (117 - i) <= 4, 117 - i, 0);
    // full: write pointer 64 ahead, then drain across the 127->0 wrap
    step(0, 0, 56, 120, 0, 0, 64, 0);
    for (int i = 1; i <= 64; i++)
      step(1, 0, 56, 120 + i, i == 64, (64 - i) <= 4, 64 - i, 0);
    step(1, 0, 56, 56, 1, 1, 0, 1);
    step(0, 1, 56, 56, 1, 1, 0, 0);
    // concurrent pop and write advance keeps level constant
    step(0, 0, 61, 56, 0, 0, 5, 0);
    step(1, 0, 62, 57, 0, 0, 5, 0);
    step(1, 0, 63, 58, 0, 0, 5, 0);
    step(1, 0, 63, 59, 0, 1, 4, 0);
    rst_cyc();
    step(0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 1, 1, 0);
    step(1, 0, 1, 1, 1, 1, 0, 0);
    repeat (3) @(negedge clock_read);
    cmp("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
